// File: rtl/sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port_ctrl
//   Burst controller for a 256x32 single-port SRAM macro (NCE/NWRT/RA/CA/DIN/DO).
//   Burst commands, a write-beat stream and a read-beat stream are turned
//   into SRAM cycles. The two-edge read latency of the macro is absorbed by a
//   small read FIFO. A read is issued only when the FIFO is sure to have room
//   for its data when that data comes back.
//
//   Optional feature macro: SRAM_CTRL_STAT_EN adds stat_wr_cnt / stat_rd_cnt.
//
// Ports
//   CLK, RST           clock (posedge) and synchronous active-high reset
//   cmd_*              burst command: wr selects direction, addr = start word,
//                      len = beats minus one
//   wr_valid/ready/data  write beat stream into the controller
//   rd_valid/ready/data  read beat stream out of the controller (FIFO head)
//   busy               FSM not idle, or read data still buffered
//   dbg_state          current FSM state (IDLE=0, WRITE=1, READ=2, DRAIN=3)
//   NCE, NWRT, RA, CA, DIN   registered SRAM controls, address and write data
//   DO                 SRAM read data, valid one cycle after the SRAM samples
//   stat_wr_cnt/rd_cnt (SRAM_CTRL_STAT_EN only) SRAM writes issued / read
//                      beats delivered, both wrap at 16 bits
//
// Handshakes (cmd, wr, rd): a transfer happens on a rising CLK edge where
// valid and ready are both 1. The sender holds its payload stable while
// valid is 1 and ready is 0. Neither side makes valid depend on ready.
// ---------------------------------------------------------------------------
module sram_port_ctrl #(
    parameter int DW  = 32,
    parameter int AW  = 8,
    parameter int RAW = 6,
    parameter int CAW = 2,
    parameter int RDQ = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_wr,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [AW-1:0]  cmd_len,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [DW-1:0]  wr_data,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [DW-1:0]  rd_data,
    output logic           busy,
    output logic [1:0]     dbg_state,
    output logic           NCE,
    output logic           NWRT,
    output logic [RAW-1:0] RA,
    output logic [CAW-1:0] CA,
    output logic [DW-1:0]  DIN,
    input  logic [DW-1:0]  DO
`ifdef SRAM_CTRL_STAT_EN
    ,
    output logic [15:0]    stat_wr_cnt,
    output logic [15:0]    stat_rd_cnt
`endif
);

    localparam int QAW = $clog2(RDQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   rem;

    // Read pipeline: rd_p0 = read driven onto the SRAM pins this cycle,
    // rd_p1 = DO carries that read's data and is pushed at the next edge.
    logic            rd_p0;
    logic            rd_p1;

    logic [DW-1:0]   fifo_mem [RDQ];
    logic [QAW-1:0]  wptr;
    logic [QAW-1:0]  rptr;
    logic [QAW:0]    occ;

    logic            cmd_fire;
    logic            wr_fire;
    logic            rd_fire;
    logic            rd_issue;
    logic            credit_ok;
    logic [QAW+1:0]  credit_used;

    // Every read in flight already owns a FIFO slot, so the capture of DO
    // can never find the FIFO full.
    assign credit_used = {1'b0, occ}
                       + {{(QAW+1){1'b0}}, rd_p0}
                       + {{(QAW+1){1'b0}}, rd_p1};
    assign credit_ok   = credit_used < (QAW+2)'(RDQ);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_valid  = (occ != '0);
    assign rd_data   = fifo_mem[rptr];
    assign rd_fire   = rd_valid && rd_ready;
    assign busy      = (state != S_IDLE) || (occ != '0);
    assign dbg_state = state;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_nx = cmd_wr ? S_WRITE : S_READ;
            S_WRITE: if (wr_fire && (rem == '0)) state_nx = S_IDLE;
            S_READ:  if (rd_issue && (rem == '0)) state_nx = S_DRAIN;
            S_DRAIN: if (!rd_p0 && !rd_p1) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_issue  = 1'b0;
        if (!RST) begin
            case (state)
                S_IDLE:  cmd_ready = 1'b1;
                S_WRITE: wr_ready  = 1'b1;
                S_READ:  rd_issue  = credit_ok;
                default: ;
            endcase
        end
    end

    // SRAM pin registers, burst address/count, read pipeline and FIFO pointers
    always_ff @(posedge CLK) begin
        if (RST) begin
            NCE   <= 1'b1;
            NWRT  <= 1'b1;
            RA    <= '0;
            CA    <= '0;
            DIN   <= '0;
            addr  <= '0;
            rem   <= '0;
            rd_p0 <= 1'b0;
            rd_p1 <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
        end else begin
            NCE   <= 1'b1;
            NWRT  <= 1'b1;
            rd_p0 <= rd_issue;
            rd_p1 <= rd_p0;
            if (cmd_fire) begin
                addr <= cmd_addr;
                rem  <= cmd_len;
            end
            if (wr_fire) begin
                NCE      <= 1'b0;
                NWRT     <= 1'b0;
                {RA, CA} <= addr;
                DIN      <= wr_data;
                addr     <= addr + 1'b1;
                rem      <= rem - 1'b1;
            end
            if (rd_issue) begin
                NCE      <= 1'b0;
                {RA, CA} <= addr;
                addr     <= addr + 1'b1;
                rem      <= rem - 1'b1;
            end
            if (rd_p1) wptr <= wptr + 1'b1;
            if (rd_fire) rptr <= rptr + 1'b1;
            occ <= occ + {{QAW{1'b0}}, rd_p1} - {{QAW{1'b0}}, rd_fire};
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (rd_p1) fifo_mem[wptr] <= DO;
    end

`ifdef SRAM_CTRL_STAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (wr_fire) stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (rd_fire) stat_rd_cnt <= stat_rd_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_port_ctrl
//   Bench for sram_port_ctrl with a behavioural SRAM model. The reference is
//   a plain word array holding what the bench wrote. Each burst is expanded
//   up front into the list of SRAM accesses it must produce (kind, address,
//   data) and the list of read beats it must return. Directed bursts are
//   followed by randomized bursts with random write gaps and random rd_ready.
// ---------------------------------------------------------------------------
module tb_sram_port_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int RDQ = 4;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [1:0]    dbg_state;
    logic          NCE, NWRT;
    logic [5:0]    RA;
    logic [1:0]    CA;
    logic [DW-1:0] DIN, DO;
`ifdef SRAM_CTRL_STAT_EN
    logic [15:0]   stat_wr_cnt, stat_rd_cnt;
`endif

    sram_port_ctrl dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .dbg_state(dbg_state),
        .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .DO(DO)
`ifdef SRAM_CTRL_STAT_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
    );

    // SRAM macro model: samples pins on the edge after they are registered;
    // read data is on DO after that edge.
    logic [DW-1:0] sram [256];
    always @(posedge CLK) begin
        if (!NCE) begin
            if (!NWRT) sram[{RA, CA}] <= DIN;
            else       DO <= sram[{RA, CA}];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] ref_mem [256];
    logic [40:0]   exp_acc_q[$];   // {is_write, addr, write data or 0}
    logic [DW-1:0] exp_rd_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int rd_mode = 0;               // 0: ready high, 1: ready low, 2: random
    int issued = 0;
    int taken = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sink-side ready generator (sole driver of rd_ready)
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'b0;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: values at the falling edge show what the last rising edge
    // registered and what the next rising edge will transfer.
    always @(negedge CLK) begin
        if (!NCE) begin
            check("acc_expected", exp_acc_q.size() != 0, 1);
            if (exp_acc_q.size() != 0)
                check("acc", {~NWRT, RA, CA, (NWRT ? 32'h0 : DIN)}, exp_acc_q.pop_front());
            if (NWRT) issued++;
        end
        if (RST) begin
            issued = 0;
            taken  = 0;
        end else begin
            if (rd_valid && rd_ready) begin
                check("rd_expected", exp_rd_q.size() != 0, 1);
                if (exp_rd_q.size() != 0) check("rd_data", rd_data, exp_rd_q.pop_front());
                taken++;
            end
            check("rd_credit", (issued - taken) <= RDQ, 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [7:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge CLK);
        while (!cmd_ready && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("cmd_accept_timeout", n >= 1000, 0);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Expands a burst into expected accesses/beats, then drives it.
    // dmode 0: random data, otherwise data = base + beat index.
    // gap_mode 0: none, 1: gap before every beat after the first, 2: random.
    task automatic run_burst(input bit wr, input logic [7:0] a, input int len,
                             input int dmode, input logic [31:0] base, input int gap_mode);
        logic [31:0] wq[$];
        logic [7:0]  ad;
        logic [31:0] d;
        int n;
        for (int i = 0; i <= len; i++) begin
            ad = a + 8'(i);
            if (wr) begin
                d = (dmode == 0) ? $urandom : base + 32'(i);
                ref_mem[ad] = d;
                wq.push_back(d);
                exp_acc_q.push_back({1'b1, ad, d});
            end else begin
                exp_acc_q.push_back({1'b0, ad, 32'h0});
                exp_rd_q.push_back(ref_mem[ad]);
            end
        end
        send_cmd(wr, a, 8'(len));
        if (wr) begin
            for (int i = 0; i <= len; i++) begin
                if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
                    wr_valid = 1'b0;
                    @(posedge CLK);
                    #1;
                    check("wr_gap_nce", NCE, 1);
                end
                wr_valid = 1'b1;
                wr_data  = wq[i];
                n = 0;
                @(negedge CLK);
                while (!wr_ready && n < 100) begin
                    @(negedge CLK);
                    n++;
                end
                @(posedge CLK);
                #1;
            end
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge CLK);
        while ((exp_acc_q.size() != 0 || exp_rd_q.size() != 0 || busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_timeout"}, n >= 3000, 0);
        @(posedge CLK);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int lat;
        int beats;
        RST = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_ready", wr_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_nce", NCE, 1);
        check("rst_nwrt", NWRT, 1);
        check("rst_addr", {RA, CA}, 0);
        check("rst_din", DIN, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_cmd_ready_after", cmd_ready, 1);
`ifdef SRAM_CTRL_STAT_EN
        check("rst_stat_wr", stat_wr_cnt, 0);
        check("rst_stat_rd", stat_rd_cnt, 0);
`endif
        @(posedge CLK);
        #1;

        // 1: write 0x10..0x13 with 0xA0..0xA3, back-to-back
        run_burst(1'b1, 8'h10, 3, 1, 32'hA0, 0);
        check("t1_last_beat_nce", NCE, 0);
        wait_done("t1");
        check("t1_idle", dbg_state, 0);

        // 2: read it back; first beat two cycles after first issue, 4 in a row
        run_burst(1'b0, 8'h10, 3, 0, 32'h0, 0);
        n = 0;
        @(negedge CLK);
        while (!(NCE == 1'b0 && NWRT == 1'b1) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        lat = 0;
        while (!rd_valid && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("t2_latency", lat, 2);
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            if (rd_valid && rd_ready) beats++;
            @(negedge CLK);
        end
        check("t2_back_to_back", beats, 4);
        wait_done("t2");
`ifdef SRAM_CTRL_STAT_EN
        check("stat_wr_4", stat_wr_cnt, 4);
        check("stat_rd_4", stat_rd_cnt, 4);
`endif

        // full 256-beat write: longest burst, fills the whole array
        run_burst(1'b1, 8'h00, 255, 0, 32'h0, 0);
        wait_done("full");

        // 3: wrap at the top of the address space
        run_burst(1'b1, 8'hFE, 3, 1, 32'h1, 0);
        wait_done("t3w");
        run_burst(1'b0, 8'hFE, 3, 0, 32'h0, 0);
        wait_done("t3r");

        // 4: read len=7 with the sink stalled; FIFO fills to depth, issue stops
        rd_mode = 1;
        @(posedge CLK);
        #1;
        run_burst(1'b0, 8'h10, 7, 0, 32'h0, 0);
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        check("t4_stall_nce", NCE, 1);
        check("t4_buffered", issued - taken, 4);
        check("t4_rd_valid", rd_valid, 1);
        rd_mode = 0;
        wait_done("t4");

        // 5a: write with a gap before every beat, then read back
        run_burst(1'b1, 8'h40, 3, 0, 32'h0, 1);
        wait_done("t5w");
        run_burst(1'b0, 8'h40, 3, 0, 32'h0, 0);
        wait_done("t5r");

        // 5b: reset in the middle of a read burst
        run_burst(1'b0, 8'h20, 15, 0, 32'h0, 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        exp_acc_q.delete();
        exp_rd_q.delete();
        check("t5_rst_nce", NCE, 1);
        check("t5_rst_cmd_ready", cmd_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("t5_rd_valid", rd_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
`ifdef SRAM_CTRL_STAT_EN
        check("t5_stat_wr", stat_wr_cnt, 0);
        check("t5_stat_rd", stat_rd_cnt, 0);
`endif
        @(posedge CLK);
        #1;

        // randomized bursts; reads may still drain while the next one starts
        rd_mode = 2;
        for (int b = 0; b < 24; b++) begin
            run_burst(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      $urandom_range(0, 15), 0, 32'h0, 2);
            if ($urandom_range(0, 1) == 1) wait_done("rnd");
        end
        rd_mode = 0;
        wait_done("final");
        check("final_acc_q", exp_acc_q.size(), 0);
        check("final_rd_q", exp_rd_q.size(), 0);
        check("final_idle", dbg_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
